// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised register file.
// Holds the clear-engine state encoding and the packed-port slice helper.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } clr_state_t;

    // Low bit of port 'port' inside a bus of equal-width packed slices.
    function automatic int port_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear engine: walks every entry writing zero after reset or on clr_req,
// and reports ready once the array is fully cleared.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ENTRY = ADDR_W'(DEPTH - 1);

    clr_state_t state;

    // The terminal check is an explicit compare so the sweep never depends on counter wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            clr_we  <= 1'b1;
            ready   <= 1'b0;
        end else begin
            unique case (state)
                ST_CLEAR: begin
                    if (clr_cnt == LAST_ENTRY) begin
                        state   <= ST_IDLE;
                        clr_cnt <= '0;
                        clr_we  <= 1'b0;
                        ready   <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (clr_req) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                        clr_we  <= 1'b1;
                        ready   <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_CLEAR;
                    clr_cnt <= '0;
                    clr_we  <= 1'b1;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/param_register_file.sv
// Parametrised multi-read-port register file with clear engine and ready/done handshake.
// Define REGFILE_BYPASS_EN for write-first forwarding on same-cycle read/write collisions.
module param_register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     reg_write,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     clr_req,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     done,
    output logic                     ready
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]        mem [DEPTH];
    logic [ADDR_W-1:0]        rd_a [NUM_RD];
    logic [NUM_RD*DATA_W-1:0] rd_next;
    logic                     clr_we;
    logic [ADDR_W-1:0]        clr_cnt;
    logic                     accept;
    logic                     wr_ok;

    regfile_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_req (clr_req),
        .ready   (ready),
        .clr_we  (clr_we),
        .clr_cnt (clr_cnt)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_addr
        assign rd_a[k] = rd_addr[port_lo(k, ADDR_W) +: ADDR_W];
    end

    // A pending clear request wins over an access presented in the same cycle.
    assign accept = en && ready && !clr_req;
    assign wr_ok  = accept && reg_write && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_next = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_next[port_lo(k, DATA_W) +: DATA_W] = mem[rd_a[k]];
`ifdef REGFILE_BYPASS_EN
            if (reg_write && (wr_addr == rd_a[k])) begin
                rd_next[port_lo(k, DATA_W) +: DATA_W] = wr_data;
            end
`endif
            if ((ZERO_REG != 0) && (rd_a[k] == '0)) begin
                rd_next[port_lo(k, DATA_W) +: DATA_W] = '0;
            end
        end
    end

    // Read data only updates on an accepted access, otherwise it holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            done    <= 1'b0;
        end else begin
            done <= accept;
            if (accept) begin
                rd_data <= rd_next;
            end
        end
    end

endmodule
